bram_share_arbiter: RTL and testbench

- Shares the single-port user BRAM between two requesters: the Wishbone slave path from the management SoC, and a local accelerator engine port.
- Sits between the Wishbone slave signals, the engine, and the bram instance (CLK/WE0/EN0/Di0/Do0/A0).
- Grants one requester at a time using 2-way round-robin.
- Sequences each BRAM access with a programmable wait-state count and returns a one-cycle ack to the granted requester.

---
 rtl/bram_share_arbiter_pkg.sv | 19 +
 rtl/bram_share_arbiter_if.sv | 46 ++++
 rtl/bram_share_arbiter_rr2.sv | 21 ++
 rtl/bram_share_arbiter.sv | 119 +++++++++++
 tb/tb_bram_share_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bram_share_arbiter_pkg.sv
// rtl/bram_share_arbiter_pkg.sv - shared types and constants for the BRAM share arbiter
package bram_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic {
    REQ_WB  = 1'b0,
    REQ_ENG = 1'b1
  } req_id_e;

  localparam logic [11:0] DEFAULT_BASE = 12'h380;
  localparam int          CNT_W        = 16;

endpackage

// File: rtl/bram_share_arbiter_if.sv
// rtl/bram_share_arbiter_if.sv - Wishbone, engine and BRAM signal bundle
// slave = arbiter side; master = requesters plus the BRAM macro.
interface bram_share_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;

  logic              eng_req;
  logic [3:0]        eng_wstrb;
  logic [ADDR_W-1:0] eng_addr;
  logic [31:0]       eng_wdata;
  logic              eng_ack;
  logic [31:0]       eng_rdata;

  logic [3:0]        bram_we;
  logic              bram_en;
  logic [31:0]       bram_di;
  logic [ADDR_W-1:0] bram_a;
  logic [31:0]       bram_do;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  eng_req, eng_wstrb, eng_addr, eng_wdata,
    output eng_ack, eng_rdata,
    output bram_we, bram_en, bram_di, bram_a,
    input  bram_do
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output eng_req, eng_wstrb, eng_addr, eng_wdata,
    input  eng_ack, eng_rdata,
    input  bram_we, bram_en, bram_di, bram_a,
    output bram_do
  );

endinterface

// File: rtl/bram_share_arbiter_rr2.sv
// rtl/bram_share_arbiter_rr2.sv - two-way round-robin winner select
// A tie goes to whichever requester was not granted last.
module bram_share_rr2
  import bram_share_arbiter_pkg::*;
(
  input  logic    req_wb,
  input  logic    req_eng,
  input  req_id_e last_grant,
  output req_id_e winner
);

  always_comb begin
    winner = REQ_WB;
    if (req_wb && req_eng) begin
      winner = (last_grant == REQ_WB) ? REQ_ENG : REQ_WB;
    end else if (req_eng) begin
      winner = REQ_ENG;
    end
  end

endmodule

// File: rtl/bram_share_arbiter.sv
// rtl/bram_share_arbiter.sv - shares one single-port BRAM between Wishbone and an engine
// Optional ack counters enabled by BRAM_SHARE_ARBITER_PERF_EN.
module bram_share_arbiter
  import bram_share_arbiter_pkg::*;
#(
  parameter int          DELAYS = 10,
  parameter int          ADDR_W = 32,
  parameter logic [11:0] BASE   = DEFAULT_BASE
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  bram_share_arbiter_if.slave bus
`ifdef BRAM_SHARE_ARBITER_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_wb_cnt,
  output logic [CNT_W-1:0] perf_eng_cnt
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAYS - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  req_id_e          last_grant, grant, winner;
  logic [3:0]       we_lat;
  logic             wb_req, any_req, ack_wb, ack_eng;
  logic [3:0]       wb_wstrb;
  logic [31:0]      rd_val;

  assign wb_req   = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:20] == BASE);
  assign wb_wstrb = bus.wbs_sel_i & {4{bus.wbs_we_i}};
  assign any_req  = wb_req | bus.eng_req;
  // Writes return zero so a stale read word never leaks through a write ack.
  assign rd_val   = (we_lat == 4'h0) ? bus.bram_do : 32'h0;

  bram_share_rr2 u_rr2 (
    .req_wb     (wb_req),
    .req_eng    (bus.eng_req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = ST_WAIT;
      ST_WAIT:   if (cnt == CNT_LAST) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign bus.bram_en   = (state == ST_ACCESS);
  assign bus.bram_we   = bus.bram_en ? we_lat : 4'h0;
  assign ack_wb        = (state == ST_RESP) && (grant == REQ_WB);
  assign ack_eng       = (state == ST_RESP) && (grant == REQ_ENG);
  assign bus.wbs_ack_o = ack_wb;
  assign bus.eng_ack   = ack_eng;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt           <= '0;
      last_grant    <= REQ_ENG;
      grant         <= REQ_WB;
      we_lat        <= 4'h0;
      bus.bram_a    <= '0;
      bus.bram_di   <= 32'h0;
      bus.wbs_dat_o <= 32'h0;
      bus.eng_rdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant      <= winner;
            last_grant <= winner;
            if (winner == REQ_WB) begin
              bus.bram_a  <= ADDR_W'(bus.wbs_adr_i);
              bus.bram_di <= bus.wbs_dat_i;
              we_lat      <= wb_wstrb;
            end else begin
              bus.bram_a  <= bus.eng_addr;
              bus.bram_di <= bus.eng_wdata;
              we_lat      <= bus.eng_wstrb;
            end
          end
        end
        ST_ACCESS: cnt <= '0;
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          // Do0 is valid on the first WAIT edge only.
          if (cnt == '0) begin
            if (grant == REQ_WB) bus.wbs_dat_o <= rd_val;
            else                 bus.eng_rdata <= rd_val;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BRAM_SHARE_ARBITER_PERF_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      perf_wb_cnt  <= '0;
      perf_eng_cnt <= '0;
    end else begin
      if (ack_wb && perf_wb_cnt != {CNT_W{1'b1}})   perf_wb_cnt  <= perf_wb_cnt + 1'b1;
      if (ack_eng && perf_eng_cnt != {CNT_W{1'b1}}) perf_eng_cnt <= perf_eng_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_share_arbiter.sv
// tb/tb_bram_share_arbiter.sv - directed vector bench for bram_share_arbiter
module tb_bram_share_arbiter;
  import bram_share_arbiter_pkg::*;

  localparam int DELAYS = 10;
  localparam int LAT    = DELAYS + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_share_arbiter_if #(.ADDR_W(32)) ifc ();

`ifdef BRAM_SHARE_ARBITER_PERF_EN
  logic [15:0] perf_wb_cnt, perf_eng_cnt;
`endif

  bram_share_arbiter #(.DELAYS(DELAYS), .ADDR_W(32), .BASE(12'h380)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (ifc)
`ifdef BRAM_SHARE_ARBITER_PERF_EN
    ,
    .perf_wb_cnt  (perf_wb_cnt),
    .perf_eng_cnt (perf_eng_cnt)
`endif
  );

  // Byte-write BRAM model, word index from address bits [9:2]
  logic [31:0] mem [0:255] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ifc.bram_en) begin
      for (int b = 0; b < 4; b++)
        if (ifc.bram_we[b]) mem[ifc.bram_a[9:2]][8*b +: 8] <= ifc.bram_di[8*b +: 8];
      ifc.bram_do <= mem[ifc.bram_a[9:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check32({tag, "_wbs_ack"},  {31'h0, ifc.wbs_ack_o}, 32'h0);
    check32({tag, "_eng_ack"},  {31'h0, ifc.eng_ack},   32'h0);
    check32({tag, "_bram_en"},  {31'h0, ifc.bram_en},   32'h0);
    check32({tag, "_bram_we"},  {28'h0, ifc.bram_we},   32'h0);
    check32({tag, "_bram_a"},   ifc.bram_a,             32'h0);
    check32({tag, "_bram_di"},  ifc.bram_di,            32'h0);
    check32({tag, "_wbs_dat"},  ifc.wbs_dat_o,          32'h0);
    check32({tag, "_eng_rdat"}, ifc.eng_rdata,          32'h0);
  endtask

  task automatic drop_all();
    ifc.wbs_cyc_i = 1'b0; ifc.wbs_stb_i = 1'b0; ifc.wbs_we_i = 1'b0;
    ifc.eng_req   = 1'b0;
  endtask

  task automatic drive_wb(input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] data);
    ifc.wbs_cyc_i = 1'b1; ifc.wbs_stb_i = 1'b1;
    ifc.wbs_we_i  = |strb;
    ifc.wbs_sel_i = (strb == 4'h0) ? 4'hF : strb;
    ifc.wbs_adr_i = addr; ifc.wbs_dat_i = data;
  endtask

  task automatic drive_eng(input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] data);
    ifc.eng_req = 1'b1; ifc.eng_wstrb = strb; ifc.eng_addr = addr; ifc.eng_wdata = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycle 0 is the first cycle the request is visible; ack expected at cycle DELAYS+2.
  task automatic do_access(input bit eng, input logic [3:0] strb, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output int lat,
                           output logic [3:0] we1, output logic en1, output logic other_ack);
    @(posedge clk); #1;
    if (eng) drive_eng(strb, addr, wdata);
    else     drive_wb(strb, addr, wdata);
    lat = -1; we1 = 4'h0; en1 = 1'b0; other_ack = 1'b0; rdata = 32'hx;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 1) begin we1 = ifc.bram_we; en1 = ifc.bram_en; end
      if (eng ? ifc.wbs_ack_o : ifc.eng_ack) other_ack = 1'b1;
      if (eng ? ifc.eng_ack : ifc.wbs_ack_o) begin
        lat = c;
        rdata = eng ? ifc.eng_rdata : ifc.wbs_dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    drop_all();
  endtask

  // Both request in the same cycle; each drops the cycle after its own ack.
  task automatic do_tie(output int wb_at, output int eng_at,
                        output logic [31:0] wb_dat, output logic [31:0] eng_dat);
    @(posedge clk); #1;
    drive_wb(4'h0, 32'h3800_0004, 32'h0);
    drive_eng(4'h0, 32'h0000_0008, 32'h0);
    wb_at = -1; eng_at = -1; wb_dat = 32'hx; eng_dat = 32'hx;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (ifc.wbs_ack_o && wb_at < 0)  begin wb_at = c;  wb_dat = ifc.wbs_dat_o; end
      if (ifc.eng_ack && eng_at < 0)   begin eng_at = c; eng_dat = ifc.eng_rdata; end
      @(posedge clk); #1;
      if (wb_at >= 0) begin ifc.wbs_cyc_i = 1'b0; ifc.wbs_stb_i = 1'b0; end
      if (eng_at >= 0) ifc.eng_req = 1'b0;
      if (wb_at >= 0 && eng_at >= 0) break;
    end
    drop_all();
  endtask

  typedef struct {
    bit          eng;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] rdata, d1, d2;
    logic [3:0]  we1;
    logic        en1, oth;
    int          lat, t_wb, t_eng, bad_en, bad_ack;

    vecs[0] = '{1'b0, 4'hF,    32'h3800_0004, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 4'h0,    32'h3800_0004, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 4'hF,    32'h0000_0008, 32'hFFFF_FFFF, 32'h0};
    vecs[3] = '{1'b1, 4'b0011, 32'h0000_0008, 32'h1234_5678, 32'h0};
    vecs[4] = '{1'b1, 4'h0,    32'h0000_0008, 32'h0,         32'hFFFF_5678};
    vecs[5] = '{1'b0, 4'h0,    32'h3800_0008, 32'h0,         32'hFFFF_5678};
    vecs[6] = '{1'b1, 4'h0,    32'h0000_0004, 32'h0,         32'hDEAD_BEEF};
    vecs[7] = '{1'b0, 4'b1100, 32'h3800_0010, 32'hAABB_CCDD, 32'h0};
    vecs[8] = '{1'b0, 4'h0,    32'h3800_0010, 32'h0,         32'hAABB_0000};

    drop_all();
    ifc.wbs_sel_i = 4'h0; ifc.wbs_adr_i = 32'h0; ifc.wbs_dat_i = 32'h0;
    ifc.eng_wstrb = 4'h0; ifc.eng_addr = 32'h0; ifc.eng_wdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_access(vecs[i].eng, vecs[i].strb, vecs[i].addr, vecs[i].wdata, rdata, lat, we1, en1, oth);
      check32($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check32($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check32($sformatf("vec%0d_we_cycle1", i), {28'h0, we1}, {28'h0, vecs[i].strb});
      check32($sformatf("vec%0d_en_cycle1", i), {31'h0, en1}, 32'h1);
      check32($sformatf("vec%0d_other_ack", i), {31'h0, oth}, 32'h0);
    end

    // Tie right after reset: Wishbone first, engine DELAYS+3 later
    do_reset();
    do_tie(t_wb, t_eng, d1, d2);
    check32("tie1_wb_at", 32'(t_wb), 32'(LAT));
    check32("tie1_eng_at", 32'(t_eng), 32'(2 * LAT + 1));
    check32("tie1_wb_dat", d1, 32'hDEAD_BEEF);
    check32("tie1_eng_dat", d2, 32'hFFFF_5678);

    // Lone Wishbone access leaves last_grant=WB, so the next tie goes to the engine
    do_access(1'b0, 4'h0, 32'h3800_0004, 32'h0, rdata, lat, we1, en1, oth);
    check32("solo_wb_latency", 32'(lat), 32'(LAT));
    do_tie(t_wb, t_eng, d1, d2);
    check32("tie2_eng_at", 32'(t_eng), 32'(LAT));
    check32("tie2_wb_at", 32'(t_wb), 32'(2 * LAT + 1));

    // Out-of-range Wishbone address held for 30 cycles
    @(posedge clk); #1;
    drive_wb(4'hF, 32'h3000_0000, 32'h5555_5555);
    bad_en = 0; bad_ack = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ifc.bram_en)   bad_en++;
      if (ifc.wbs_ack_o) bad_ack++;
    end
    @(posedge clk); #1 drop_all();
    check32("oor_bram_en_cycles", 32'(bad_en), 32'h0);
    check32("oor_ack_cycles", 32'(bad_ack), 32'h0);

    // Reset asserted in cycle 5 of a read (WAIT state)
    @(posedge clk); #1;
    drive_wb(4'h0, 32'h3800_0004, 32'h0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_outputs_zero("midreset");
    drop_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bad_ack = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifc.wbs_ack_o || ifc.eng_ack) bad_ack++;
    end
    check32("midreset_no_ack", 32'(bad_ack), 32'h0);
    do_access(1'b0, 4'h0, 32'h3800_0004, 32'h0, rdata, lat, we1, en1, oth);
    check32("post_reset_latency", 32'(lat), 32'(LAT));
    check32("post_reset_rdata", rdata, 32'hDEAD_BEEF);

`ifdef BRAM_SHARE_ARBITER_PERF_EN
    do_reset();
    check32("perf_wb_reset", {16'h0, perf_wb_cnt}, 32'h0);
    check32("perf_eng_reset", {16'h0, perf_eng_cnt}, 32'h0);
    for (int k = 0; k < 3; k++) do_access(1'b0, 4'h0, 32'h3800_0004, 32'h0, rdata, lat, we1, en1, oth);
    for (int k = 0; k < 2; k++) do_access(1'b1, 4'h0, 32'h0000_0008, 32'h0, rdata, lat, we1, en1, oth);
    check32("perf_wb_cnt", {16'h0, perf_wb_cnt}, 32'd3);
    check32("perf_eng_cnt", {16'h0, perf_eng_cnt}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
